dmem_access_scheduler: RTL and testbench

- Schedules the single-port data memory between two requesters: pipeline MEM stage (priority) and debug memory-dump engine (background bursts).
- Debug bursts are issued in cycles the pipeline leaves idle. A starvation counter forces a debug slot when the pipeline monopolises the RAM.
- Sits between the MEM stage / debug unit and the data-memory RAM. The RAM is synchronous-read with 1-cycle latency.

---
 rtl/dmem_access_scheduler.sv | 144 ++++++++++++++
 tb/tb_dmem_access_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_scheduler.sv
// Arbitrates the single-port data RAM between the MEM stage (priority) and debug read bursts.
// Optional stall statistics counter enabled by defining DMEM_SCHED_STATS_EN.
module dmem_access_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 11,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  output logic              pipe_rvalid,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [CNT_W-1:0]  dbg_count,
  output logic              dbg_busy,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DMEM_SCHED_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN, ST_DONE} state_t;

  localparam logic [7:0]        LP_STARVE_MAX = 8'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  LP_CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LP_ADDR_ONE   = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [CNT_W-1:0]  r_remain;
  logic [7:0]        r_starve;
  logic              r_pipe_rvalid;
  logic              r_dbg_rvalid;
  logic              r_dbg_busy;
  logic              r_dbg_done;

  logic              w_forced;
  logic              w_pipe_gnt;
  logic              w_dbg_issue;
  logic [ADDR_W-1:0] w_ram_addr;

  assign w_forced    = (r_state == ST_BURST) && (r_starve == LP_STARVE_MAX);
  assign w_pipe_gnt  = pipe_req & ~w_forced;
  assign w_dbg_issue = (r_state == ST_BURST) & ~w_pipe_gnt;

  // Idle cycles keep the previous address so the RAM input bus does not toggle.
  always_comb begin
    w_ram_addr = r_last_addr;
    if (w_pipe_gnt)       w_ram_addr = pipe_addr;
    else if (w_dbg_issue) w_ram_addr = r_addr;
  end

  assign pipe_stall  = pipe_req & w_forced;
  assign ram_we      = w_pipe_gnt & pipe_we & ~reset;
  assign ram_addr    = w_ram_addr;
  assign ram_wdata   = pipe_wdata;
  assign pipe_rvalid = r_pipe_rvalid;
  assign pipe_rdata  = ram_rdata;
  assign dbg_rvalid  = r_dbg_rvalid;
  assign dbg_rdata   = ram_rdata;
  assign dbg_busy    = r_dbg_busy;
  assign dbg_done    = r_dbg_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_last_addr   <= '0;
      r_remain      <= '0;
      r_starve      <= '0;
      r_pipe_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      r_dbg_busy    <= 1'b0;
      r_dbg_done    <= 1'b0;
    end else begin
      r_last_addr   <= w_ram_addr;
      r_pipe_rvalid <= w_pipe_gnt & ~pipe_we;
      r_dbg_rvalid  <= w_dbg_issue;
      case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (dbg_start && (dbg_count != '0)) begin
            r_state    <= ST_BURST;
            r_addr     <= dbg_base;
            r_remain   <= dbg_count;
            r_dbg_busy <= 1'b1;
          end else if (dbg_start) begin
            r_state    <= ST_DONE;
            r_dbg_done <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_dbg_issue) begin
            r_starve <= '0;
            r_addr   <= r_addr + LP_ADDR_ONE;
            r_remain <= r_remain - LP_CNT_ONE;
            if (r_remain == LP_CNT_ONE) begin
              r_state    <= ST_DRAIN;
              r_dbg_done <= 1'b1;
            end
          end else if (r_starve != LP_STARVE_MAX) begin
            r_starve <= r_starve + 8'd1;
          end
        end
        ST_DRAIN: begin
          r_state    <= ST_IDLE;
          r_dbg_busy <= 1'b0;
          r_dbg_done <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_dbg_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_SCHED_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_stall_cycles <= '0;
    else if (dbg_start)                           r_stall_cycles <= '0;
    else if (pipe_stall && r_stall_cycles != '1)  r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_access_scheduler.sv
// Directed bench for dmem_access_scheduler with a behavioural 1-cycle-latency RAM.
module tb_dmem_access_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_req, pipe_we;
  logic [9:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall, pipe_rvalid;
  logic [31:0] pipe_rdata;
  logic        dbg_start;
  logic [9:0]  dbg_base;
  logic [10:0] dbg_count;
  logic        dbg_busy, dbg_rvalid, dbg_done;
  logic [31:0] dbg_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef DMEM_SCHED_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_rv    = 0;
  int n_done  = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  dmem_access_scheduler dut (
    .clk(clk), .reset(reset),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
    .dbg_start(dbg_start), .dbg_base(dbg_base), .dbg_count(dbg_count),
    .dbg_busy(dbg_busy), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DMEM_SCHED_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [31:0] mval(input logic [9:0] a);
    return 32'hC0DE_0000 ^ {22'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (dbg_rvalid) n_rv++;
    if (dbg_done)   n_done++;
  endtask

  initial begin
    logic [9:0] a;
    logic       s;
    int         idx;
    for (int i = 0; i < 1024; i++) mem[i] = mval(10'(i));
    reset = 1'b1; pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 10'h001; pipe_wdata = 32'h1;
    dbg_start = 1'b0; dbg_base = '0; dbg_count = '0;
    #1;
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_busy",   {31'd0, dbg_busy}, 0);
    chk("rst_done",   {31'd0, dbg_done}, 0);
    chk("rst_rvalid", {30'd0, dbg_rvalid, pipe_rvalid}, 0);
    tick(); tick();
    pipe_req = 1'b0; pipe_we = 1'b0;
    reset = 1'b0;
    tick();

    // burst wrapping past the top of memory
    dbg_start = 1'b1; dbg_base = 10'h3FE; dbg_count = 11'd4;
    tick();
    dbg_start = 1'b0; n_rv = 0; n_done = 0;
    for (int k = 0; k < 4; k++) begin
      a = 10'h3FE + 10'(k);
      #1;
      chk("t1_addr", {22'd0, ram_addr}, {22'd0, a});
      chk("t1_we", {31'd0, ram_we}, 0);
      tick();
      chk("t1_rvalid", {31'd0, dbg_rvalid}, 1);
      chk("t1_rdata", dbg_rdata, mval(a));
      chk("t1_done", {31'd0, dbg_done}, (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t1_busy_after", {31'd0, dbg_busy}, 0);
    chk("t1_nrv", n_rv, 4);
    chk("t1_ndone", n_done, 1);

    // pipeline monopolises RAM; forced slots on BURST cycles 9 and 18
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 10'h055;
    dbg_start = 1'b1; dbg_base = 10'h020; dbg_count = 11'd2;
    #1;
    chk("t2_stall_idle", {31'd0, pipe_stall}, 0);
    tick();
    dbg_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      s = (c == 9) || (c == 18);
      #1;
      chk("t2_stall", {31'd0, pipe_stall}, {31'd0, s});
      chk("t2_addr", {22'd0, ram_addr}, s ? ((c == 9) ? 32'h20 : 32'h21) : 32'h55);
      tick();
      chk("t2_pipe_rvalid", {31'd0, pipe_rvalid}, {31'd0, ~s});
      chk("t2_dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, s});
      if (c == 1) chk("t2_pipe_rdata", pipe_rdata, mval(10'h055));
      if (c == 9) chk("t2_dbg_rdata0", dbg_rdata, mval(10'h020));
    end
    chk("t2_dbg_rdata1", dbg_rdata, mval(10'h021));
    chk("t2_done", {31'd0, dbg_done}, 1);
`ifdef DMEM_SCHED_STATS_EN
    chk("t2_stall_cycles", {16'd0, stall_cycles}, 2);
`endif
    pipe_req = 1'b0;
    tick();
    chk("t2_busy_after", {31'd0, dbg_busy}, 0);

    // pipe write and debug read to the same word
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 10'h010; pipe_wdata = 32'hDEADBEEF;
    dbg_start = 1'b1; dbg_base = 10'h010; dbg_count = 11'd1;
    #1;
    chk("t3_we", {31'd0, ram_we}, 1);
    chk("t3_stall0", {31'd0, pipe_stall}, 0);
    tick();
    pipe_req = 1'b0; pipe_we = 1'b0; dbg_start = 1'b0;
    chk("t3_no_pipe_rvalid", {31'd0, pipe_rvalid}, 0);
    #1;
    chk("t3_addr", {22'd0, ram_addr}, 32'h010);
    chk("t3_rd_we", {31'd0, ram_we}, 0);
    chk("t3_stall1", {31'd0, pipe_stall}, 0);
    tick();
    chk("t3_rvalid", {31'd0, dbg_rvalid}, 1);
    chk("t3_rdata", dbg_rdata, 32'hDEADBEEF);
    chk("t3_done", {31'd0, dbg_done}, 1);
    tick();

    // restart attempt during a running burst is ignored
    dbg_start = 1'b1; dbg_base = 10'h100; dbg_count = 11'd8;
    tick();
    n_rv = 0; n_done = 0; idx = 0;
    dbg_base = 10'h300; dbg_count = 11'd3;
    #1;
    chk("t4_addr_first", {22'd0, ram_addr}, 32'h100);
    tick();
    dbg_start = 1'b0;
    if (dbg_rvalid) begin
      chk("t4_rdata", dbg_rdata, mval(10'h100 + 10'(idx)));
      idx++;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dbg_rvalid) begin
        chk("t4_rdata", dbg_rdata, mval(10'h100 + 10'(idx)));
        idx++;
      end
    end
    chk("t4_nrv", n_rv, 8);
    chk("t4_ndone", n_done, 1);
    chk("t4_busy_after", {31'd0, dbg_busy}, 0);

    // zero-length burst
    n_rv = 0; n_done = 0;
    dbg_start = 1'b1; dbg_base = 10'h000; dbg_count = 11'd0;
    tick();
    dbg_start = 1'b0;
    chk("t5_done", {31'd0, dbg_done}, 1);
    chk("t5_busy", {31'd0, dbg_busy}, 0);
    #1;
    chk("t5_we", {31'd0, ram_we}, 0);
    tick();
    chk("t5_done_clr", {31'd0, dbg_done}, 0);
    tick();
    chk("t5_nrv", n_rv, 0);
    chk("t5_ndone", n_done, 1);

    // reset mid-burst after three issued reads
    dbg_start = 1'b1; dbg_base = 10'h200; dbg_count = 11'd10;
    tick();
    dbg_start = 1'b0;
    tick(); tick(); tick();
    chk("t6_busy_pre", {31'd0, dbg_busy}, 1);
    reset = 1'b1;
    #1;
    chk("t6_busy", {31'd0, dbg_busy}, 0);
    chk("t6_rvalid", {30'd0, dbg_rvalid, pipe_rvalid}, 0);
    chk("t6_done", {31'd0, dbg_done}, 0);
    chk("t6_we", {31'd0, ram_we}, 0);
    n_rv = 0; n_done = 0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    chk("t6_nrv", n_rv, 0);
    chk("t6_ndone", n_done, 0);
    dbg_start = 1'b1; dbg_base = 10'h3F0; dbg_count = 11'd2;
    tick();
    dbg_start = 1'b0;
    tick();
    chk("t6_new_rd0", dbg_rdata, mval(10'h3F0));
    chk("t6_new_rv0", {31'd0, dbg_rvalid}, 1);
    tick();
    chk("t6_new_rd1", dbg_rdata, mval(10'h3F1));
    chk("t6_new_done", {31'd0, dbg_done}, 1);
    tick();
    chk("t6_new_busy", {31'd0, dbg_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
